dsp_mac_sequencer: RTL and testbench



---
 rtl/dsp_mac_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_sequencer.sv
// ============================================================================
// dsp_mac_sequencer : drives one DSP48A1 slice as a streaming MAC (P = sum A*B)
// Optional ABORT input enabled by defining DSP_MAC_ABORT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dsp_mac_sequencer #(
  parameter int LEN_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
`ifdef DSP_MAC_ABORT_EN
  input  logic             ABORT,
`endif
  input  logic             START,
  input  logic [LEN_W-1:0] LEN,
  output logic             BUSY,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [17:0]      IN_A,
  input  logic [17:0]      IN_B,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [47:0]      RESULT,
  output logic [17:0]      DSP_A,
  output logic [17:0]      DSP_B,
  output logic [7:0]       DSP_OPMODE,
  output logic             DSP_CE,
  output logic             DSP_RST,
  input  logic [47:0]      DSP_P
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] OPM_FIRST  = 8'h01;
  localparam logic [7:0] OPM_ACC    = 8'h09;
  localparam logic [7:0] OPM_BUBBLE = 8'h08;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             first_q, first_d;
  logic [2:0]       tag_v_q, tag_v_d;
  logic [2:0]       tag_f_q, tag_f_d;
  logic             busy_q, busy_d;
  logic             in_ready_q, in_ready_d;
  logic             res_valid_q, res_valid_d;
  logic [47:0]      result_q, result_d;
  logic [17:0]      dsp_a_q, dsp_a_d;
  logic [17:0]      dsp_b_q, dsp_b_d;
  logic [7:0]       opmode_q, opmode_d;
  logic             ce_q, ce_d;
  logic             rst_q, rst_d;

  logic handshake;
  logic abort;

`ifdef DSP_MAC_ABORT_EN
  assign abort = ABORT;
`else
  assign abort = 1'b0;
`endif

  assign handshake = (state_q == RUN) && in_ready_q && IN_VALID;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    first_d     = first_q;
    busy_d      = busy_q;
    in_ready_d  = in_ready_q;
    res_valid_d = res_valid_q;
    result_d    = result_q;
    dsp_a_d     = dsp_a_q;
    dsp_b_d     = dsp_b_q;
    ce_d        = 1'b1;
    rst_d       = 1'b0;
    tag_v_d     = {tag_v_q[1:0], handshake};
    tag_f_d     = {tag_f_q[1:0], handshake && first_q};

    unique case (state_q)
      IDLE: begin
        in_ready_d = 1'b0;
        if (START) begin
          busy_d = 1'b1;
          if (LEN != '0) begin
            // Operands are held off for the one cycle the slice spends in reset.
            state_d     = RUN;
            remaining_d = LEN;
            first_d     = 1'b1;
            rst_d       = 1'b1;
          end else begin
            state_d     = DONE;
            result_d    = '0;
            res_valid_d = 1'b1;
          end
        end
      end
      RUN: begin
        in_ready_d = 1'b1;
        if (handshake) begin
          dsp_a_d     = IN_A;
          dsp_b_d     = IN_B;
          first_d     = 1'b0;
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d    = DRAIN;
            in_ready_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        // Empty tag pipeline means the last term reached P on the previous edge.
        if (tag_v_q == 3'b000) begin
          result_d    = DSP_P;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (RES_READY) begin
          res_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      busy_d      = 1'b0;
      in_ready_d  = 1'b0;
      res_valid_d = 1'b0;
      tag_v_d     = 3'b000;
      tag_f_d     = 3'b000;
      rst_d       = 1'b1;
    end

    if (tag_v_d[1]) begin
      opmode_d = tag_f_d[1] ? OPM_FIRST : OPM_ACC;
    end else begin
      opmode_d = OPM_BUBBLE;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      first_q     <= 1'b0;
      tag_v_q     <= 3'b000;
      tag_f_q     <= 3'b000;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      result_q    <= '0;
      dsp_a_q     <= '0;
      dsp_b_q     <= '0;
      opmode_q    <= '0;
      ce_q        <= 1'b0;
      rst_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      first_q     <= first_d;
      tag_v_q     <= tag_v_d;
      tag_f_q     <= tag_f_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
      result_q    <= result_d;
      dsp_a_q     <= dsp_a_d;
      dsp_b_q     <= dsp_b_d;
      opmode_q    <= opmode_d;
      ce_q        <= ce_d;
      rst_q       <= rst_d;
    end
  end

  assign BUSY       = busy_q;
  assign IN_READY   = in_ready_q;
  assign RES_VALID  = res_valid_q;
  assign RESULT     = result_q;
  assign DSP_A      = dsp_a_q;
  assign DSP_B      = dsp_b_q;
  assign DSP_OPMODE = opmode_q;
  assign DSP_CE     = ce_q;
  assign DSP_RST    = rst_q;

endmodule

`default_nettype wire

// File: tb/tb_dsp_mac_sequencer.sv
// ============================================================================
// tb_dsp_mac_sequencer : directed bench with a DSP48A1 slice model and a
// result scoreboard. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dsp_mac_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
`ifdef DSP_MAC_ABORT_EN
  logic        ABORT = 1'b0;
`endif
  logic        START = 1'b0;
  logic [15:0] LEN = '0;
  logic        BUSY;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [17:0] IN_A = '0;
  logic [17:0] IN_B = '0;
  logic        RES_VALID;
  logic        RES_READY = 1'b0;
  logic [47:0] RESULT;
  logic [17:0] DSP_A;
  logic [17:0] DSP_B;
  logic [7:0]  DSP_OPMODE;
  logic        DSP_CE;
  logic        DSP_RST;
  logic [47:0] DSP_P;

  dsp_mac_sequencer #(.LEN_W(16)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
`ifdef DSP_MAC_ABORT_EN
    .ABORT      (ABORT),
`endif
    .START      (START),
    .LEN        (LEN),
    .BUSY       (BUSY),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .IN_A       (IN_A),
    .IN_B       (IN_B),
    .RES_VALID  (RES_VALID),
    .RES_READY  (RES_READY),
    .RESULT     (RESULT),
    .DSP_A      (DSP_A),
    .DSP_B      (DSP_B),
    .DSP_OPMODE (DSP_OPMODE),
    .DSP_CE     (DSP_CE),
    .DSP_RST    (DSP_RST),
    .DSP_P      (DSP_P)
  );

  always #5 CLK = ~CLK;

  // Slice model: A1/B1 -> M -> P with registered OPMODE, synchronous reset.
  logic [17:0] a1 = '0, b1 = '0;
  logic [35:0] m = '0;
  logic [7:0]  opreg = '0;
  logic [47:0] p = '0;
  logic [47:0] x_mux, z_mux;

  assign x_mux = (opreg[1:0] == 2'b01) ? {12'd0, m} : 48'd0;
  assign z_mux = (opreg[3:2] == 2'b10) ? p : 48'd0;
  assign DSP_P = p;

  always @(posedge CLK) begin
    if (DSP_RST) begin
      a1 <= '0; b1 <= '0; m <= '0; opreg <= '0; p <= '0;
    end else if (DSP_CE) begin
      a1    <= DSP_A;
      b1    <= DSP_B;
      m     <= a1 * b1;
      opreg <= DSP_OPMODE;
      p     <= x_mux + z_mux;
    end
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int start_cyc = 0;
  logic [47:0] sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_cmd(input logic [15:0] len, input logic [47:0] exp, input bit push);
    START = 1'b1;
    LEN   = len;
    if (push) sb.push_back(exp);
    step();
    START = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic send(input string tag, input logic [17:0] a, input logic [17:0] b);
    int n = 0;
    IN_A = a;
    IN_B = b;
    IN_VALID = 1'b1;
    while (!IN_READY && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check({tag, "_ready_timeout"}, 0, 1);
    step();
    IN_VALID = 1'b0;
  endtask

  task automatic get_result(input string tag, input int lat, input int hold);
    int n = 0;
    logic [47:0] exp;
    while (!RES_VALID && n < 100) begin
      step();
      n++;
    end
    check({tag, "_res_valid"}, RES_VALID, 1);
    if (RES_VALID) begin
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        check({tag, "_result"}, RESULT, exp);
        check({tag, "_latency"}, cyc - start_cyc, lat);
        for (int i = 0; i < hold; i++) begin
          START = 1'b1;
          LEN   = 16'd5;
          step();
          check({tag, "_hold_valid"}, RES_VALID, 1);
          check({tag, "_hold_result"}, RESULT, exp);
        end
      end else begin
        check({tag, "_unexpected_result"}, 1, 0);
      end
      RES_READY = 1'b1;
      step();
      RES_READY = 1'b0;
      START = 1'b0;
      check({tag, "_consumed"}, RES_VALID, 0);
      check({tag, "_idle_busy"}, BUSY, 0);
    end
  endtask

  initial begin
    bit seen;
    // Power-on reset and reset values
    #1 RST_N = 1'b0;
    #1;
    check("rst_busy", BUSY, 0);
    check("rst_in_ready", IN_READY, 0);
    check("rst_res_valid", RES_VALID, 0);
    check("rst_result", RESULT, 0);
    check("rst_dsp_a", DSP_A, 0);
    check("rst_dsp_b", DSP_B, 0);
    check("rst_opmode", DSP_OPMODE, 0);
    check("rst_ce", DSP_CE, 0);
    check("rst_dsp_rst", DSP_RST, 1);
    step();
    step();
    RST_N = 1'b1;
    check("post_rst_dsp_rst", DSP_RST, 1);
    step();
    check("post_rst_dsp_rst_clear", DSP_RST, 0);
    check("post_rst_ce", DSP_CE, 1);
    check("post_rst_opmode", DSP_OPMODE, 8'h08);
    step();

    // LEN=3 continuous stream: 2*3+4*5+6*7 = 68
    start_cmd(16'd3, 48'd68, 1'b1);
    check("t1_busy", BUSY, 1);
    check("t1_dsp_rst_pulse", DSP_RST, 1);
    send("t1", 18'd2, 18'd3);
    send("t1", 18'd4, 18'd5);
    send("t1", 18'd6, 18'd7);
    get_result("t1", 8, 0);

    // LEN=2 with two bubble cycles; opmode 01,08,08,09
    start_cmd(16'd2, 48'd1000001, 1'b1);
    send("t2", 18'd1000, 18'd1000);
    step();
    check("t2_opm_first", DSP_OPMODE, 8'h01);
    step();
    check("t2_opm_bubble0", DSP_OPMODE, 8'h08);
    send("t2", 18'd1, 18'd1);
    check("t2_opm_bubble1", DSP_OPMODE, 8'h08);
    step();
    check("t2_opm_acc", DSP_OPMODE, 8'h09);
    get_result("t2", 9, 0);

    // LEN=0: immediate zero result, slice operands untouched
    start_cmd(16'd0, 48'd0, 1'b1);
    check("t3_dsp_a", DSP_A, 18'd1);
    check("t3_dsp_b", DSP_B, 18'd1);
    get_result("t3", 0, 0);

    // Back-to-back with held result; START during DONE ignored
    start_cmd(16'd1, 48'd9, 1'b1);
    send("t4a", 18'd3, 18'd3);
    get_result("t4a", 6, 4);
    start_cmd(16'd1, 48'd25, 1'b1);
    send("t4b", 18'd5, 18'd5);
    get_result("t4b", 6, 0);

    // Asynchronous reset mid-command
    start_cmd(16'd4, 48'd0, 1'b0);
    send("t5", 18'd100, 18'd100);
    send("t5", 18'd200, 18'd200);
    RST_N = 1'b0;
    #1;
    check("t5_rst_busy", BUSY, 0);
    check("t5_rst_in_ready", IN_READY, 0);
    check("t5_rst_res_valid", RES_VALID, 0);
    check("t5_rst_result", RESULT, 0);
    check("t5_rst_dsp_a", DSP_A, 0);
    check("t5_rst_opmode", DSP_OPMODE, 0);
    check("t5_rst_ce", DSP_CE, 0);
    check("t5_rst_dsp_rst", DSP_RST, 1);
    step();
    step();
    RST_N = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (RES_VALID) seen = 1'b1;
    end
    check("t5_no_partial", seen, 0);
    start_cmd(16'd1, 48'd56, 1'b1);
    send("t5b", 18'd7, 18'd8);
    get_result("t5b", 6, 0);

`ifdef DSP_MAC_ABORT_EN
    // Abort during DRAIN
    start_cmd(16'd2, 48'd0, 1'b0);
    send("t6", 18'd9, 18'd9);
    send("t6", 18'd9, 18'd9);
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;
    check("t6_abort_busy", BUSY, 0);
    check("t6_abort_dsp_rst", DSP_RST, 1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (RES_VALID) seen = 1'b1;
      step();
    end
    check("t6_no_result", seen, 0);
    start_cmd(16'd1, 48'd4, 1'b1);
    send("t6b", 18'd2, 18'd2);
    get_result("t6b", 6, 0);
`endif

    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
